image_frame_sequencer: RTL and testbench

//  Frame-timing controller that feeds the RGB888->YCbCr444 colour-conversion pipeline.

---
 rtl/image_frame_sequencer_pkg.sv | 27 ++
 rtl/img_clken_div.sv | 35 +++
 rtl/image_frame_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_image_frame_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_frame_sequencer_pkg.sv
// rtl/image_frame_sequencer_pkg.sv - shared FSM encodings, RGB field offsets and counter width helpers
package image_frame_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_BACK   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_FRONT  = 3'd4,
        ST_DRAIN  = 3'd5
    } state_t;

    localparam int RGB_W     = 24;
    localparam int RED_LSB   = 16;
    localparam int GREEN_LSB = 8;
    localparam int BLUE_LSB  = 0;

    // Never returns 0 so a count whose maximum is 0 still gets a legal 1-bit register.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/img_clken_div.sv
// rtl/img_clken_div.sv - pixel tick generator: one tick every DIV clocks, with sync clear and enable
module img_clken_div
    import image_frame_sequencer_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last,
    output logic tick_next
);
    localparam int W = cnt_width(DIV - 1);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;
    logic         tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

    assign tick = (cnt == '0);
    assign last = (cnt == LAST);
    // Look-ahead so the parent can register outputs that line up with the tick cycle.
    assign tick_next = clr | (en ? last : tick);

endmodule

// File: rtl/image_frame_sequencer.sv
// rtl/image_frame_sequencer.sv - frame timing and pixel fetch for the RGB->YCbCr conversion pipeline
module image_frame_sequencer
    import image_frame_sequencer_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int H_BLANK   = 16,
    parameter int V_ACTIVE  = 480,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 2,
    parameter int V_FRONT   = 2,
    parameter int CLKEN_DIV = 2,
    parameter int PIPE_LAT  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        cont,
    input  logic        abort,
    input  logic        src_valid,
    input  logic [23:0] src_data,
    output logic        src_ready,
    output logic        per_frame_vsync,
    output logic        per_frame_href,
    output logic        per_frame_clken,
    output logic [7:0]  per_img_red,
    output logic [7:0]  per_img_green,
    output logic [7:0]  per_img_blue,
    output logic        busy,
    output logic        done,
    output logic        err_underflow,
    output logic [15:0] frame_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int HW = cnt_width(H_TOTAL - 1);
    localparam int VW = cnt_width(max_int(max_int(V_SYNC, V_BACK), max_int(V_ACTIVE, V_FRONT)) - 1);
    localparam int DW = cnt_width(PIPE_LAT - 1);

    state_t          state, state_d;
    logic [HW-1:0]   h_cnt, h_d;
    logic [VW-1:0]   v_cnt, v_d;
    logic [DW-1:0]   drain_cnt, drain_d;
    logic [15:0]     frame_d;
    logic            done_d;
    logic            running, div_last, tick_next, accept_start;
    logic            vsync_d, href_d, clken_d, busy_d;
    int              cur_lines;

    // Zero-line vertical regions are skipped by sliding forward to the next populated one.
    function automatic state_t first_from(input state_t s);
        state_t r;
        r = s;
        if (r == ST_SYNC   && V_SYNC   == 0) r = ST_BACK;
        if (r == ST_BACK   && V_BACK   == 0) r = ST_ACTIVE;
        if (r == ST_ACTIVE && V_ACTIVE == 0) r = ST_FRONT;
        if (r == ST_FRONT  && V_FRONT  == 0) r = ST_DRAIN;
        return r;
    endfunction

    assign running      = state inside {ST_SYNC, ST_BACK, ST_ACTIVE, ST_FRONT};
    assign accept_start = (state == ST_IDLE) && start && !abort;

    img_clken_div #(.DIV(CLKEN_DIV)) u_clken_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (!running || abort),
        .en        (running),
        .last      (div_last),
        .tick_next (tick_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            h_cnt     <= '0;
            v_cnt     <= '0;
            drain_cnt <= '0;
            frame_cnt <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            h_cnt     <= h_d;
            v_cnt     <= v_d;
            drain_cnt <= drain_d;
            frame_cnt <= frame_d;
            done      <= done_d;
        end
    end

    always_comb begin
        cur_lines = 0;
        case (state)
            ST_SYNC:   cur_lines = V_SYNC;
            ST_BACK:   cur_lines = V_BACK;
            ST_ACTIVE: cur_lines = V_ACTIVE;
            ST_FRONT:  cur_lines = V_FRONT;
            default:   cur_lines = 0;
        endcase
    end

    always_comb begin
        state_d = state;
        h_d     = h_cnt;
        v_d     = v_cnt;
        drain_d = drain_cnt;
        frame_d = frame_cnt;
        done_d  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_d = first_from(ST_SYNC);
            end
            ST_DRAIN: begin
                if (32'(drain_cnt) == PIPE_LAT - 1) begin
                    drain_d = '0;
                    done_d  = 1'b1;
                    frame_d = frame_cnt + 16'd1;
                    state_d = cont ? first_from(ST_SYNC) : ST_IDLE;
                end else begin
                    drain_d = drain_cnt + 1'b1;
                end
            end
            default: begin
                // h/v only move on the last clock of a pixel period, so line edges stay tick-aligned.
                if (div_last) begin
                    if (32'(h_cnt) == H_TOTAL - 1) begin
                        h_d = '0;
                        if (32'(v_cnt) == cur_lines - 1) begin
                            v_d     = '0;
                            state_d = first_from(state_t'(state + 3'd1));
                        end else begin
                            v_d = v_cnt + 1'b1;
                        end
                    end else begin
                        h_d = h_cnt + 1'b1;
                    end
                end
            end
        endcase
        if (abort) begin
            state_d = ST_IDLE;
            h_d     = '0;
            v_d     = '0;
            drain_d = '0;
            frame_d = frame_cnt;
            done_d  = 1'b0;
        end
    end

    always_comb begin
        vsync_d   = (state_d == ST_SYNC);
        href_d    = (state_d == ST_ACTIVE) && (32'(h_d) < H_ACTIVE);
        clken_d   = href_d && tick_next;
        busy_d    = (state_d != ST_IDLE);
        src_ready = clken_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_frame_vsync <= 1'b0;
            per_frame_href  <= 1'b0;
            per_frame_clken <= 1'b0;
            busy            <= 1'b0;
            per_img_red     <= '0;
            per_img_green   <= '0;
            per_img_blue    <= '0;
            err_underflow   <= 1'b0;
        end else begin
            per_frame_vsync <= vsync_d;
            per_frame_href  <= href_d;
            per_frame_clken <= clken_d;
            busy            <= busy_d;
            if (clken_d) begin
                per_img_red   <= src_valid ? src_data[RED_LSB   +: 8] : 8'd0;
                per_img_green <= src_valid ? src_data[GREEN_LSB +: 8] : 8'd0;
                per_img_blue  <= src_valid ? src_data[BLUE_LSB  +: 8] : 8'd0;
            end else if (!href_d) begin
                per_img_red   <= '0;
                per_img_green <= '0;
                per_img_blue  <= '0;
            end
            if (accept_start) begin
                err_underflow <= 1'b0;
            end else if (clken_d && !src_valid) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_image_frame_sequencer.sv
// tb/tb_image_frame_sequencer.sv - scoreboard bench for image_frame_sequencer with small frame geometry
module tb_image_frame_sequencer;
    import image_frame_sequencer_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        cont;
    logic        abort;
    logic        src_valid;
    logic [23:0] src_data;
    logic        src_ready;
    logic        per_frame_vsync;
    logic        per_frame_href;
    logic        per_frame_clken;
    logic [7:0]  per_img_red;
    logic [7:0]  per_img_green;
    logic [7:0]  per_img_blue;
    logic        busy;
    logic        done;
    logic        err_underflow;
    logic [15:0] frame_cnt;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [23:0] exp_q[$];
    int          slot = 0;
    int          idx = 0;
    int          hole = -1;
    int          ready_cnt = 0;
    logic        xfer_pend = 1'b0;
    logic        valid_pend = 1'b0;
    int          exp_fc = 0;

    image_frame_sequencer #(
        .H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(2), .V_SYNC(1),
        .V_BACK(1), .V_FRONT(1), .CLKEN_DIV(2), .PIPE_LAT(3)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .cont            (cont),
        .abort           (abort),
        .src_valid       (src_valid),
        .src_data        (src_data),
        .src_ready       (src_ready),
        .per_frame_vsync (per_frame_vsync),
        .per_frame_href  (per_frame_href),
        .per_frame_clken (per_frame_clken),
        .per_img_red     (per_img_red),
        .per_img_green   (per_img_green),
        .per_img_blue    (per_img_blue),
        .busy            (busy),
        .done            (done),
        .err_underflow   (err_underflow),
        .frame_cnt       (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] pix(input int k);
        return 24'h010203 + 24'(k) * 24'h010101;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_src();
        src_valid = (slot != hole);
        src_data  = pix(idx);
    endtask

    always @(negedge clk) begin
        xfer_pend  = src_ready;
        valid_pend = src_valid;
    end

    always @(posedge clk) begin
        #1;
        if (xfer_pend) begin
            ready_cnt++;
            slot++;
            if (valid_pend) idx++;
        end
        xfer_pend = 1'b0;
        drive_src();
    end

    // Pixel scoreboard monitor
    always @(negedge clk) begin
        logic [23:0] got;
        logic [23:0] want;
        if (rst_n && per_frame_clken) begin
            got = {per_img_red, per_img_green, per_img_blue};
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL pixel_unexpected: got 0x%06h, expected no pixel", got);
            end else begin
                want = exp_q.pop_front();
                chk("pixel_data", 32'(got), 32'(want));
            end
        end
    end

    task automatic run_frame(input string tag, input int hole_slot, input int extra_start);
        int bad_v, bad_h, bad_c, bad_d, bad_b, bad_z, k, r0;
        logic ev, eh, ec, ed, eb;
        bad_v = 0; bad_h = 0; bad_c = 0; bad_d = 0; bad_b = 0; bad_z = 0; k = 0;
        slot = 0; idx = 0; hole = hole_slot;
        drive_src();
        for (int i = 0; i < 8; i++) begin
            if (i == hole_slot) exp_q.push_back(24'h0);
            else begin exp_q.push_back(pix(k)); k++; end
        end
        r0 = ready_cnt;
        exp_fc++;
        @(posedge clk); #1;
        start = 1'b1;
        for (int rel = 0; rel <= 68; rel++) begin
            @(negedge clk);
            ev = (rel >= 1 && rel <= 12);
            eh = (rel >= 25 && rel <= 32) || (rel >= 37 && rel <= 44);
            ec = eh && ((rel - 25) % 2 == 0);
            ed = (rel == 64);
            eb = (rel >= 1 && rel <= 63);
            if (per_frame_vsync !== ev) bad_v++;
            if (per_frame_href !== eh) bad_h++;
            if (per_frame_clken !== ec) bad_c++;
            if (done !== ed) bad_d++;
            if (busy !== eb) bad_b++;
            if (!eh && {per_img_red, per_img_green, per_img_blue} !== 24'h0) bad_z++;
            @(posedge clk); #1;
            start = (rel + 1 == extra_start);
        end
        chk({tag, "_vsync_bad_cycles"}, bad_v, 0);
        chk({tag, "_href_bad_cycles"}, bad_h, 0);
        chk({tag, "_clken_bad_cycles"}, bad_c, 0);
        chk({tag, "_done_bad_cycles"}, bad_d, 0);
        chk({tag, "_busy_bad_cycles"}, bad_b, 0);
        chk({tag, "_rgb_outside_href"}, bad_z, 0);
        chk({tag, "_src_ready_count"}, ready_cnt - r0, 8);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), exp_fc);
        chk({tag, "_err_underflow"}, 32'(err_underflow), (hole_slot >= 0) ? 1 : 0);
        chk({tag, "_pixels_left"}, exp_q.size(), 0);
    endtask

    task automatic run_cont();
        int bad_d, bad_b, r0, fc0;
        logic ed, eb;
        bad_d = 0; bad_b = 0;
        slot = 0; idx = 0; hole = -1;
        drive_src();
        for (int i = 0; i < 24; i++) exp_q.push_back(pix(i));
        r0 = ready_cnt;
        fc0 = exp_fc;
        @(posedge clk); #1;
        cont = 1'b1;
        start = 1'b1;
        for (int rel = 0; rel <= 195; rel++) begin
            @(negedge clk);
            if (rel == 1) chk("cont_err_cleared_by_start", 32'(err_underflow), 0);
            ed = (rel == 64) || (rel == 127) || (rel == 190);
            eb = (rel >= 1 && rel <= 189);
            if (done !== ed) bad_d++;
            if (busy !== eb) bad_b++;
            if (rel == 64) begin
                chk("cont_vsync_after_drain1", 32'(per_frame_vsync), 1);
                chk("cont_frame_cnt1", 32'(frame_cnt), fc0 + 1);
            end
            if (rel == 127) begin
                chk("cont_vsync_after_drain2", 32'(per_frame_vsync), 1);
                chk("cont_frame_cnt2", 32'(frame_cnt), fc0 + 2);
            end
            if (rel == 190) chk("cont_frame_cnt3", 32'(frame_cnt), fc0 + 3);
            @(posedge clk); #1;
            start = 1'b0;
            if (rel == 150) cont = 1'b0;
        end
        exp_fc = fc0 + 3;
        chk("cont_done_bad_cycles", bad_d, 0);
        chk("cont_busy_bad_cycles", bad_b, 0);
        chk("cont_src_ready_count", ready_cnt - r0, 24);
        chk("cont_pixels_left", exp_q.size(), 0);
    endtask

    task automatic run_abort();
        int bad_d;
        bad_d = 0;
        slot = 0; idx = 0; hole = 1;
        drive_src();
        exp_q.push_back(pix(0));
        exp_q.push_back(24'h0);
        exp_q.push_back(pix(1));
        @(posedge clk); #1;
        start = 1'b1;
        for (int rel = 0; rel <= 100; rel++) begin
            @(negedge clk);
            if (rel == 29) chk("abort_pre_href", 32'(per_frame_href), 1);
            if (rel == 31)
                chk("abort_outputs_low", 32'({per_frame_vsync, per_frame_href, per_frame_clken, busy}), 0);
            if (done) bad_d++;
            @(posedge clk); #1;
            start = 1'b0;
            abort = (rel + 1 == 30);
        end
        chk("abort_no_done", bad_d, 0);
        chk("abort_frame_cnt_kept", 32'(frame_cnt), exp_fc);
        chk("abort_err_kept", 32'(err_underflow), 1);
        chk("abort_pixels_left", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; cont = 1'b0; abort = 1'b0;
        drive_src();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'({src_ready, per_frame_vsync, per_frame_href, per_frame_clken, busy, done,
                                  err_underflow, per_img_red, per_img_green, per_img_blue}), 0);
        chk("reset_frame_cnt", 32'(frame_cnt), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_frame("basic", -1, -1);
        run_frame("underflow", 3, -1);
        run_cont();
        run_abort();
        run_frame("post_abort", -1, -1);
        run_frame("busy_start", -1, 20);

        slot = 0; idx = 0; hole = -1;
        drive_src();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_vsync", 32'(per_frame_vsync), 1);
        rst_n = 1'b0;
        #1;
        chk("midframe_reset_outputs", 32'({src_ready, per_frame_vsync, per_frame_href, per_frame_clken, busy,
                                           done, err_underflow, per_img_red, per_img_green, per_img_blue}), 0);
        chk("midframe_reset_frame_cnt", 32'(frame_cnt), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_fc = 0;
        run_frame("after_reset", -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
